bcd_to_bin: RTL and testbench

Iterative packed-BCD to binary converter, the inverse of the team's binary-to-BCD decoder. It accepts a DIGITS-digit packed BCD word on a start/busy/done handshake. It folds one digit per clock (most significant digit first) into a binary accumulator and presents the result on a registered output. It sits between the BCD keypad/display front end and the arithmetic datapath.

---
 rtl/bcd_to_bin.sv | 132 +++++++++++++
 tb/tb_bcd_to_bin.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD_TO_BIN_CHECK_EN to flag words containing nibbles above 9 (err=1, bin_out all ones).
module bcd_to_bin #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  bin_q, bin_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  step_c;

`ifdef BCD_TO_BIN_CHECK_EN
    logic inv_q, inv_d;
    logic err_q, err_d;
    logic any_bad_c;

    // Flag any non-decimal nibble in the incoming word.
    always_comb begin
        any_bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) any_bad_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Horner step: acc*10 + top digit, with *10 as shift-and-add.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
        inv_d   = inv_q;
        err_d   = err_q;
`endif
        step_c  = (acc_q << 3) + (acc_q << 1) + W'(sr_q[W-1 -: 4]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
`ifdef BCD_TO_BIN_CHECK_EN
                    inv_d   = any_bad_c;
`endif
                end
            end
            CONV: begin
                acc_d = step_c;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIGITS - 1)) begin
                    bin_d   = step_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef BCD_TO_BIN_CHECK_EN
                    err_d   = inv_q;
                    if (inv_q) bin_d = '1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed testbench for bcd_to_bin: DIGITS=2 main instance plus DIGITS=4 and DIGITS=1 corner instances.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;

    logic        start2, busy2, done2, err2;
    logic [7:0]  bcd2, bin2;
    logic        start4, busy4, done4, err4;
    logic [15:0] bcd4, bin4;
    logic        start1, busy1, done1, err1;
    logic [3:0]  bcd1, bin1;

    int n_checks;
    int n_fail;
    int n_done;

    bcd_to_bin #(.DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    bcd_to_bin #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .bcd_in(bcd4),
        .busy(busy4), .done(done4), .bin_out(bin4), .err(err4)
    );

    bcd_to_bin #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
        .busy(busy1), .done(done1), .bin_out(bin1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DIGITS=2 conversion; returns right after the done cycle is observed.
    task automatic run2(input string tag, input logic [7:0] bcd, input logic [7:0] exp_bin,
                        input logic exp_err);
        int n;
        start2 = 1'b1;
        bcd2   = bcd;
        tick();
        start2 = 1'b0;
        check({tag, " busy"}, 32'(busy2), 32'd1);
        n = 0;
        while (!done2 && n < 10) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd2);
        check({tag, " bin"}, 32'(bin2), 32'(exp_bin));
        check({tag, " err"}, 32'(err2), 32'(exp_err));
        check({tag, " busy end"}, 32'(busy2), 32'd0);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        n_done   = 0;
        rst    = 1'b1;
        start2 = 1'b0; bcd2 = '0;
        start4 = 1'b0; bcd4 = '0;
        start1 = 1'b0; bcd1 = '0;
        tick();
        tick();
        check("reset busy", 32'(busy2), 32'd0);
        check("reset done", 32'(done2), 32'd0);
        check("reset bin",  32'(bin2),  32'd0);
        check("reset err",  32'(err2),  32'd0);
        rst = 1'b0;
        tick();

        // 99 -> 0x63, then hold
        run2("c99", 8'h99, 8'h63, 1'b0);
        tick();
        check("c99 done width", 32'(done2), 32'd0);
        check("c99 hold", 32'(bin2), 32'h63);
        tick();

        // Back-to-back: start raised in the cycle after each done
        run2("c00", 8'h00, 8'd0,  1'b0);
        run2("c15", 8'h15, 8'd15, 1'b0);
        run2("c42", 8'h42, 8'd42, 1'b0);
        tick();
        check("c42 done width", 32'(done2), 32'd0);

        // Non-decimal nibble
`ifdef BCD_TO_BIN_CHECK_EN
        run2("c4A", 8'h4A, 8'hFF, 1'b1);
`else
        run2("c4A", 8'h4A, 8'd50, 1'b0);
`endif
        tick();

        // start/bcd_in changes during CONV are ignored
        start2 = 1'b1;
        bcd2   = 8'h23;
        tick();
        bcd2   = 8'h77;
        check("ign busy", 32'(busy2), 32'd1);
        tick();
        check("ign no early done", 32'(done2), 32'd0);
        tick();
        start2 = 1'b0;
        check("ign done", 32'(done2), 32'd1);
        check("ign bin", 32'(bin2), 32'd23);
        check("ign err", 32'(err2), 32'd0);
        tick();
        check("ign single done", 32'(done2), 32'd0);
        check("ign idle", 32'(busy2), 32'd0);

        // Asynchronous reset mid-conversion (err/bin carry prior non-zero values)
`ifdef BCD_TO_BIN_CHECK_EN
        run2("c4A2", 8'h4A, 8'hFF, 1'b1);
`else
        run2("c4A2", 8'h4A, 8'd50, 1'b0);
`endif
        tick();
        start2 = 1'b1;
        bcd2   = 8'h56;
        tick();
        start2 = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst busy", 32'(busy2), 32'd0);
        check("arst done", 32'(done2), 32'd0);
        check("arst bin",  32'(bin2),  32'd0);
        check("arst err",  32'(err2),  32'd0);
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done2) n_done++;
        end
        check("arst no done", 32'(n_done), 32'd0);
        run2("c56", 8'h56, 8'd56, 1'b0);
        tick();

        // DIGITS=4 corner
        start4 = 1'b1;
        bcd4   = 16'h9999;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            tick();
            n++;
        end
        check("d4 latency", 32'(n), 32'd4);
        check("d4 bin", 32'(bin4), 32'd9999);
        check("d4 err", 32'(err4), 32'd0);
        tick();

        // DIGITS=1 corner
        start1 = 1'b1;
        bcd1   = 4'h7;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            tick();
            n++;
        end
        check("d1 latency", 32'(n), 32'd1);
        check("d1 bin", 32'(bin1), 32'd7);
        check("d1 busy end", 32'(busy1), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
